// File: rtl/cache_hit_unit.sv
// Tag-lookup front end for a 4-line fully associative cache: per-line tag compare,
// priority encode to a line index, and a registered copy captured on lookup.
module cache_hit_unit #(
    parameter int unsigned TAG_WIDTH = 28,
    parameter int unsigned NUM_LINES = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           lookup,
    input  logic [TAG_WIDTH-1:0]           input_tag,
    input  logic [NUM_LINES*TAG_WIDTH-1:0] stored_tags,
    input  logic [NUM_LINES-1:0]           valid,
    output logic [NUM_LINES-1:0]           hit_signals,
    output logic                           hit,
    output logic [1:0]                     line_number,
    output logic                           multi_hit,
    output logic                           hit_q,
    output logic [1:0]                     line_number_q,
    output logic                           multi_hit_q,
    output logic                           result_valid
);

    logic       hit_d;
    logic [1:0] line_number_d;
    logic       multi_hit_d;
    logic       result_valid_d;

    // Line 0 lands in the MSB so the encoder below favours the lowest line.
    for (genvar g = 0; g < NUM_LINES; g++) begin : g_cmp
        assign hit_signals[NUM_LINES-1-g] =
            valid[g] && (stored_tags[g*TAG_WIDTH +: TAG_WIDTH] == input_tag);
    end

    assign hit = |hit_signals;

    always_comb begin
        line_number = 2'd0;
        if (hit_signals[3]) begin
            line_number = 2'd0;
        end else if (hit_signals[2]) begin
            line_number = 2'd1;
        end else if (hit_signals[1]) begin
            line_number = 2'd2;
        end else if (hit_signals[0]) begin
            line_number = 2'd3;
        end
    end

    always_comb begin
        multi_hit = 1'b0;
        for (int i = 0; i < NUM_LINES; i++) begin
            for (int j = i + 1; j < NUM_LINES; j++) begin
                if (hit_signals[i] && hit_signals[j]) begin
                    multi_hit = 1'b1;
                end
            end
        end
    end

    always_comb begin
        hit_d          = hit_q;
        line_number_d  = line_number_q;
        multi_hit_d    = multi_hit_q;
        result_valid_d = 1'b0;
        if (lookup) begin
            hit_d          = hit;
            line_number_d  = line_number;
            multi_hit_d    = multi_hit;
            result_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_q         <= 1'b0;
            line_number_q <= 2'd0;
            multi_hit_q   <= 1'b0;
            result_valid  <= 1'b0;
        end else begin
            hit_q         <= hit_d;
            line_number_q <= line_number_d;
            multi_hit_q   <= multi_hit_d;
            result_valid  <= result_valid_d;
        end
    end

endmodule

// File: tb/tb_cache_hit_unit.sv
// Directed and randomised bench for cache_hit_unit; registered results are checked
// against a scoreboard queue filled when each lookup is driven.
module tb_cache_hit_unit;

    localparam int unsigned TW = 28;

    typedef struct packed {
        logic       hit;
        logic [1:0] line;
        logic       multi;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          lookup;
    logic [TW-1:0] input_tag;
    logic [TW-1:0] line_tag [4];
    logic [4*TW-1:0] stored_tags;
    logic [3:0]    valid;
    logic [3:0]    hit_signals;
    logic          hit;
    logic [1:0]    line_number;
    logic          multi_hit;
    logic          hit_q;
    logic [1:0]    line_number_q;
    logic          multi_hit_q;
    logic          result_valid;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];
    exp_t last;

    assign stored_tags = {line_tag[3], line_tag[2], line_tag[1], line_tag[0]};

    always #5 clk = ~clk;

    cache_hit_unit #(
        .TAG_WIDTH (TW),
        .NUM_LINES (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .lookup        (lookup),
        .input_tag     (input_tag),
        .stored_tags   (stored_tags),
        .valid         (valid),
        .hit_signals   (hit_signals),
        .hit           (hit),
        .line_number   (line_number),
        .multi_hit     (multi_hit),
        .hit_q         (hit_q),
        .line_number_q (line_number_q),
        .multi_hit_q   (multi_hit_q),
        .result_valid  (result_valid)
    );

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic set_lines(input logic [TW-1:0] t0, input logic [TW-1:0] t1,
                             input logic [TW-1:0] t2, input logic [TW-1:0] t3,
                             input logic [3:0] v);
        line_tag[0] = t0;
        line_tag[1] = t1;
        line_tag[2] = t2;
        line_tag[3] = t3;
        valid       = v;
    endtask

    task automatic check_comb(input string name, input logic [TW-1:0] tag,
                              input logic [3:0] hs, input logic [1:0] ln, input logic mh);
        input_tag = tag;
        #1;
        chk({name, ".hit_signals"}, hit_signals, hs);
        chk({name, ".hit"}, {3'b0, hit}, {3'b0, |hs});
        chk({name, ".line_number"}, {2'b0, line_number}, {2'b0, ln});
        chk({name, ".multi_hit"}, {3'b0, multi_hit}, {3'b0, mh});
    endtask

    // Independent reference: scan lines 0..3, first hit wins, count hits.
    function automatic exp_t model(input logic [TW-1:0] tag);
        exp_t e;
        int   n;
        e = '0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (valid[i] && line_tag[i] == tag) begin
                if (n == 0) e.line = 2'(i);
                n++;
            end
        end
        e.hit   = (n > 0);
        e.multi = (n > 1);
        return e;
    endfunction

    // Drive lookup across one edge, then pop and compare the captured result.
    task automatic do_lookup(input string name, input exp_t e);
        sb_q.push_back(e);
        lookup = 1'b1;
        @(posedge clk);
        #1;
        lookup = 1'b0;
        chk({name, ".result_valid"}, {3'b0, result_valid}, 4'b0001);
        checks++;
        assert (sb_q.size() > 0) else begin
            failures++;
            $error("FAIL %s.scoreboard got=empty exp=entry", name);
        end
        if (sb_q.size() > 0) begin
            last = sb_q.pop_front();
            chk({name, ".hit_q"}, {3'b0, hit_q}, {3'b0, last.hit});
            chk({name, ".line_number_q"}, {2'b0, line_number_q}, {2'b0, last.line});
            chk({name, ".multi_hit_q"}, {3'b0, multi_hit_q}, {3'b0, last.multi});
        end
    endtask

    task automatic idle_check(input string name);
        @(posedge clk);
        #1;
        chk({name, ".result_valid"}, {3'b0, result_valid}, 4'b0000);
        chk({name, ".hit_q_held"}, {3'b0, hit_q}, {3'b0, last.hit});
        chk({name, ".line_q_held"}, {2'b0, line_number_q}, {2'b0, last.line});
        chk({name, ".multi_q_held"}, {3'b0, multi_hit_q}, {3'b0, last.multi});
    endtask

    initial begin
        exp_t e;
        reset     = 1'b1;
        lookup    = 1'b0;
        input_tag = '0;
        set_lines('0, '0, '0, '0, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.hit_q", {3'b0, hit_q}, 4'b0000);
        chk("rst.line_number_q", {2'b0, line_number_q}, 4'b0000);
        chk("rst.multi_hit_q", {3'b0, multi_hit_q}, 4'b0000);
        chk("rst.result_valid", {3'b0, result_valid}, 4'b0000);
        reset = 1'b0;

        // Matching tags on invalid lines never hit.
        set_lines(28'h55, 28'h55, 28'h55, 28'h55, 4'b0000);
        check_comb("all_invalid", 28'h55, 4'b0000, 2'd0, 1'b0);

        set_lines(28'h1, 28'h2, 28'h3, 28'h4, 4'b1111);
        check_comb("tag3", 28'h3, 4'b0010, 2'd2, 1'b0);
        check_comb("sweep0", 28'h1, 4'b1000, 2'd0, 1'b0);
        check_comb("sweep1", 28'h2, 4'b0100, 2'd1, 1'b0);
        check_comb("sweep2", 28'h3, 4'b0010, 2'd2, 1'b0);
        check_comb("sweep3", 28'h4, 4'b0001, 2'd3, 1'b0);
        check_comb("miss", 28'h5, 4'b0000, 2'd0, 1'b0);
        // Differs only in the top tag bit.
        check_comb("msb_diff", 28'h8000004, 4'b0000, 2'd0, 1'b0);

        set_lines(28'h0, 28'hABC, 28'hABC, 28'hABC, 4'b1010);
        check_comb("multi13", 28'hABC, 4'b0101, 2'd1, 1'b1);
        set_lines(28'hABC, 28'hABC, 28'hABC, 28'hABC, 4'b1111);
        check_comb("multi_all", 28'hABC, 4'b1111, 2'd0, 1'b1);

        // Single lookup with line 3 hitting, then hold.
        set_lines(28'h1, 28'h2, 28'h3, 28'h4, 4'b1111);
        input_tag = 28'h4;
        do_lookup("lk_line3", '{hit: 1'b1, line: 2'd3, multi: 1'b0});
        input_tag = 28'h1;
        idle_check("lk_line3_after");

        // Back-to-back lookups: new data each cycle, result_valid stays high.
        set_lines(28'h0, 28'hABC, 28'hABC, 28'hABC, 4'b1010);
        input_tag = 28'hABC;
        do_lookup("b2b_multi", '{hit: 1'b1, line: 2'd1, multi: 1'b1});
        set_lines(28'h1, 28'h2, 28'h3, 28'h4, 4'b1111);
        input_tag = 28'h3;
        do_lookup("b2b_line2", '{hit: 1'b1, line: 2'd2, multi: 1'b0});
        idle_check("b2b_after");

        // Reset wins over lookup; the lookup is discarded.
        input_tag = 28'h2;
        reset     = 1'b1;
        lookup    = 1'b1;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        lookup = 1'b0;
        chk("rstlk.hit_q", {3'b0, hit_q}, 4'b0000);
        chk("rstlk.line_number_q", {2'b0, line_number_q}, 4'b0000);
        chk("rstlk.multi_hit_q", {3'b0, multi_hit_q}, 4'b0000);
        chk("rstlk.result_valid", {3'b0, result_valid}, 4'b0000);
        last = '0;
        idle_check("rstlk_next");
        input_tag = 28'h9;
        do_lookup("miss_lookup", '{hit: 1'b0, line: 2'd0, multi: 1'b0});

        // Randomised lookups over a small tag pool so hits and multi-hits occur.
        for (int n = 0; n < 24; n++) begin
            set_lines(28'($urandom_range(1, 4)), 28'($urandom_range(1, 4)),
                      28'($urandom_range(1, 4)), 28'($urandom_range(1, 4)),
                      4'($urandom_range(0, 15)));
            input_tag = 28'($urandom_range(1, 4));
            e = model(input_tag);
            #1;
            chk("rnd.hit", {3'b0, hit}, {3'b0, e.hit});
            chk("rnd.line_number", {2'b0, line_number}, {2'b0, e.line});
            chk("rnd.multi_hit", {3'b0, multi_hit}, {3'b0, e.multi});
            do_lookup("rnd", e);
        end
        idle_check("rnd_after");

        checks++;
        assert (sb_q.size() == 0) else begin
            failures++;
            $error("FAIL sb_drain got=%0d exp=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cache_hit_unit.md
# cache_hit_unit

Tag-lookup front end for the 4-line fully associative cache. It compares one incoming address tag against the four stored line tags, qualifying each with its valid bit. A priority encoder reduces the per-line hits to a 2-bit line index. Combinational results feed the cache's same-cycle read/write path, and a registered copy is captured on request for pipelined use.

## Interface
- TAG_WIDTH, 28, tag bits compared per line; 32-bit address minus 4 offset bits.
- NUM_LINES, 4, number of lines; fixed at 4, and the encoder is sized for it.

Ports:
- clk  in  1  system clock; all registers update on the rising edge.
- reset  in  1  synchronous, active-high reset.
- lookup  in  1  capture strobe; latches the combinational results into the registered outputs.
- input_tag  in  TAG_WIDTH  tag field of the requested address (address[31:4]).
- stored_tags  in  4*TAG_WIDTH  line i tag at [i*TAG_WIDTH +: TAG_WIDTH].
- valid  in  4  valid[i] = line i holds valid data.
- hit_signals  out  4  combinational per-line hits, packed {hit0,hit1,hit2,hit3}, so bit 3 = line 0 and bit 0 = line 3.
- hit  out  1  combinational OR of hit_signals.
- line_number  out  2  combinational encoded index of the hitting line.
- multi_hit  out  1  combinational; more than one line hits (error indicator).
- hit_q  out  1  registered hit.
- line_number_q  out  2  registered line_number.
- multi_hit_q  out  1  registered multi_hit.
- result_valid  out  1  registered; 1 for exactly the cycle after a captured lookup.

## Operation
- Per-line comparator: hit_i = valid[i] AND (input_tag == tag_i), with full TAG_WIDTH equality.
- An invalid line never hits, even if its tag matches.
- Packing: hit_signals = {hit0, hit1, hit2, hit3}.
- Priority encoder mapping from hit_signals to line_number:
  - bit 3 set gives 0;
  - else bit 2 gives 1;
  - else bit 1 gives 2;
  - else bit 0 gives 3;
  - no bit set gives 0.
- line_number is therefore the lowest-numbered hitting line. Consumers must gate it with hit.
- multi_hit = 1 when two or more bits of hit_signals are set. line_number still follows the priority order above.
- Registered path, on each rising clk:
  - if reset: hit_q, line_number_q, multi_hit_q and result_valid all clear to 0;
  - else if lookup: hit_q, line_number_q and multi_hit_q take the current combinational values, and result_valid goes to 1;
  - else: the result registers hold their values and result_valid goes to 0.
- Reset has priority over lookup in the same cycle.

## Timing
- Combinational outputs: zero-cycle latency. They must settle within the same cycle as any change on input_tag, stored_tags or valid, with no clock involvement.
- Registered outputs: one-cycle latency. Inputs sampled at edge N while lookup = 1 appear after edge N and hold until the next captured lookup or reset.
- result_valid: single-cycle pulse per lookup. Back-to-back lookups keep it high continuously, with new data every cycle.
- Reset values: hit_q = 0, line_number_q = 2'b00, multi_hit_q = 0, result_valid = 0.
  - Combinational outputs are not affected by reset.
- Reset mid-operation: a lookup in the reset cycle is discarded, and result_valid stays 0 in the following cycle.
- There is no internal state beyond the four result registers.

## Test plan
- All valid = 4'b0000, with input_tag equal to every stored tag -> hit_signals = 4'b0000, hit = 0, line_number = 0.
- valid = 4'b1111, tags 0x1, 0x2, 0x3, 0x4 (lines 0 to 3), input_tag = 0x3 -> hit_signals = 4'b0010, hit = 1, line_number = 2, multi_hit = 0.
- Sweep a single hit on each line 0 to 3 -> hit_signals equal to 4'b1000, 4'b0100, 4'b0010, 4'b0001, and line_number equal to 0, 1, 2, 3.
- Lines 1 and 3 both valid with tag 0xABC, input_tag = 0xABC:
  - combinational -> hit_signals = 4'b0101, line_number = 1, multi_hit = 1;
  - matching tag on line 2 but valid[2] = 0 -> line 2 does not hit.
- lookup pulsed for one cycle with line 3 hitting:
  - next cycle -> hit_q = 1, line_number_q = 3, result_valid = 1;
  - the cycle after -> result_valid = 0 and the q outputs are held.
- reset and lookup asserted together -> all q outputs and result_valid read 0 the next cycle. A later lookup on a miss -> hit_q = 0, line_number_q = 0.
